hazard_match_pipe: RTL and testbench

- Counterpart of the hazard unit: tracks register addresses and control bits for the Execute, Memory and Writeback stages.
- Produces every `Match_*`, `RegWrite*`, `MemtoRegE` and `PCSrc*` signal the hazard unit consumes.
- Applies the hazard unit's `FlushE` back onto its own E-stage register.
- Sits between the decoder/register-file read stage and the hazard unit, in parallel with the datapath pipeline registers.

---
 rtl/hazard_match_pipe.sv | 130 +++++++++++++
 tb/tb_hazard_match_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_match_pipe.sv
// E/M/W address and control tracking feeding the hazard unit's match inputs.
// Optional saturating stall/flush counters when HAZARD_PERF_CNT_EN is defined.
module hazard_match_pipe #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       PCSrcD,
  input  logic       CondExE,
  input  logic       FlushE,
  input  logic       StallD,
  output logic       Match_1E_M,
  output logic       Match_1E_W,
  output logic       Match_2E_M,
  output logic       Match_2E_W,
  output logic       Match_12D_E,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic       MemtoRegE,
  output logic       PCSrcE,
  output logic       PCSrcM,
  output logic       PCSrcW
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  logic [3:0] ra1_e, ra2_e, wa3_e;
  logic       reg_write_e, valid_e;
  logic [3:0] wa3_m, wa3_w;
  logic       mem_to_reg_m, valid_m, valid_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra1_e       <= '0;
      ra2_e       <= '0;
      wa3_e       <= '0;
      reg_write_e <= 1'b0;
      MemtoRegE   <= 1'b0;
      PCSrcE      <= 1'b0;
      valid_e     <= 1'b0;
    end else if (FlushE) begin
      ra1_e       <= '0;
      ra2_e       <= '0;
      wa3_e       <= '0;
      reg_write_e <= 1'b0;
      MemtoRegE   <= 1'b0;
      PCSrcE      <= 1'b0;
      valid_e     <= 1'b0;
    end else begin
      ra1_e       <= RA1D;
      ra2_e       <= RA2D;
      wa3_e       <= WA3D;
      reg_write_e <= RegWriteD;
      MemtoRegE   <= MemtoRegD;
      PCSrcE      <= PCSrcD;
      valid_e     <= 1'b1;
    end
  end

  // Failed condition kills the writes but keeps WA3 moving down the pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wa3_m        <= '0;
      RegWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      PCSrcM       <= 1'b0;
      valid_m      <= 1'b0;
      wa3_w        <= '0;
      RegWriteW    <= 1'b0;
      PCSrcW       <= 1'b0;
      valid_w      <= 1'b0;
    end else begin
      wa3_m        <= wa3_e;
      RegWriteM    <= reg_write_e & CondExE;
      mem_to_reg_m <= MemtoRegE;
      PCSrcM       <= PCSrcE & CondExE;
      valid_m      <= valid_e;
      wa3_w        <= wa3_m;
      RegWriteW    <= RegWriteM;
      PCSrcW       <= PCSrcM;
      valid_w      <= valid_m;
    end
  end

  logic ra1_e_ok, ra2_e_ok, ra1_d_ok, ra2_d_ok;

  // R15 reads come from PCPlus8, so they never forward.
  assign ra1_e_ok = ra1_e != 4'hF;
  assign ra2_e_ok = ra2_e != 4'hF;
  assign ra1_d_ok = RA1D != 4'hF;
  assign ra2_d_ok = RA2D != 4'hF;

  assign Match_1E_M = valid_e & valid_m & (ra1_e == wa3_m) & ra1_e_ok;
  assign Match_1E_W = valid_e & valid_w & (ra1_e == wa3_w) & ra1_e_ok;
  assign Match_2E_M = valid_e & valid_m & (ra2_e == wa3_m) & ra2_e_ok;
  assign Match_2E_W = valid_e & valid_w & (ra2_e == wa3_w) & ra2_e_ok;

  assign Match_12D_E = valid_e &
    (((RA1D == wa3_e) & ra1_d_ok) |
     ((RA2D == wa3_e) & ra2_d_ok));

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != '1))
        StallCnt <= StallCnt + 1'b1;
      if (FlushE && (FlushCnt != '1))
        FlushCnt <= FlushCnt + 1'b1;
    end
  end

  logic unused_m;
  assign unused_m = mem_to_reg_m;
`else
  logic unused_m;
  assign unused_m = ^{mem_to_reg_m, StallD, CNT_W[0]};
`endif

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Bench for hazard_match_pipe: per-cycle model compare plus directed checks.
// Counter checks are compiled in only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_match_pipe;

  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ra1_d, ra2_d, wa3_d;
  logic       rw_d, m2r_d, pcs_d, cond, flush, stall;
  logic       m1em, m1ew, m2em, m2ew, m12;
  logic       rw_m, rw_w, m2r_e, pcs_e, pcs_m, pcs_w;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_match_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(rst_n),
    .RA1D(ra1_d),
    .RA2D(ra2_d),
    .WA3D(wa3_d),
    .RegWriteD(rw_d),
    .MemtoRegD(m2r_d),
    .PCSrcD(pcs_d),
    .CondExE(cond),
    .FlushE(flush),
    .StallD(stall),
    .Match_1E_M(m1em),
    .Match_1E_W(m1ew),
    .Match_2E_M(m2em),
    .Match_2E_W(m2ew),
    .Match_12D_E(m12),
    .RegWriteM(rw_m),
    .RegWriteW(rw_w),
    .MemtoRegE(m2r_e),
    .PCSrcE(pcs_e),
    .PCSrcM(pcs_m),
    .PCSrcW(pcs_w)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt(stall_cnt),
    .FlushCnt(flush_cnt)
`endif
  );

  // Model: an instruction record per stage; empty slot = bubble.
  typedef struct {
    logic       v;
    logic [3:0] ra1, ra2, wa3;
    logic       rw, m2r, pcs;
  } slot_t;

  slot_t se, sm, sw, bubble;
  int    n_stall, n_flush;
  int    sat;

  initial begin
    bubble = '{1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    sat = (1 << CNT_W) - 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se = bubble; sm = bubble; sw = bubble;
      n_stall = 0; n_flush = 0;
    end else begin
      sw = sm;
      sm = se;
      sm.rw  = se.rw  & cond;
      sm.pcs = se.pcs & cond;
      if (flush) se = bubble;
      else se = '{1'b1, ra1_d, ra2_d, wa3_d, rw_d, m2r_d, pcs_d};
      if (stall && n_stall < sat) n_stall++;
      if (flush && n_flush < sat) n_flush++;
    end
  end

  function automatic logic hit(slot_t a, logic [3:0] src, slot_t b);
    return a.v && b.v && src == b.wa3 && src != 4'd15;
  endfunction

  function automatic logic [10:0] model_out();
    logic d;
    d = se.v && ((ra1_d == se.wa3 && ra1_d != 4'd15) ||
                 (ra2_d == se.wa3 && ra2_d != 4'd15));
    return {hit(se, se.ra1, sm), hit(se, se.ra1, sw),
            hit(se, se.ra2, sm), hit(se, se.ra2, sw), d,
            sm.rw, sw.rw, se.m2r, se.pcs, sm.pcs, sw.pcs};
  endfunction

  wire [10:0] dut_out = {m1em, m1ew, m2em, m2ew, m12,
                         rw_m, rw_w, m2r_e, pcs_e, pcs_m, pcs_w};

  always @(negedge clk) begin
    logic [10:0] exp_v;
    exp_v = model_out();
    checks++;
    if (dut_out !== exp_v) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, dut_out, exp_v);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cnt !== CNT_W'(n_stall) || flush_cnt !== CNT_W'(n_flush)) begin
      failures++;
      $display("FAIL cnt_cmp got=%0d/%0d exp=%0d/%0d",
               stall_cnt, flush_cnt, n_stall, n_flush);
    end
`endif
  end

  task automatic check(string name, logic [15:0] got, logic [15:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] a1, a2, w, input logic rw, m2r,
                       pcs, c, f, s);
    ra1_d = a1; ra2_d = a2; wa3_d = w;
    rw_d = rw; m2r_d = m2r; pcs_d = pcs;
    cond = c; flush = f; stall = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    check("reset_outs", {5'd0, dut_out}, 16'd0);
    rst_n = 1'b1;

    // Forwarding from the instruction right ahead
    drive(2, 0, 2, 1, 0, 0, 1, 0, 0);
    tick();
    drive(2, 0, 5, 0, 0, 0, 1, 0, 0);
    #1 check("d_match_r2", m12, 1);
    tick();
    check("e_m_match_r2", m1em, 1);
    check("regwrite_m", rw_m, 1);

    // ADD R3, gap, SUB reading R3
    drive(1, 1, 3, 1, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 6, 0, 0, 0, 1, 0, 0);
    tick();
    drive(3, 8, 9, 1, 0, 0, 1, 0, 0);
    tick();
    check("e_w_match_r3", m1ew, 1);
    check("e_m_nomatch", m1em, 0);
    check("regwrite_w", rw_w, 1);

    // Load-use: LDR R4 followed by a reader of R4
    drive(1, 2, 4, 1, 1, 0, 1, 0, 0);
    tick();
    drive(4, 0, 7, 1, 0, 0, 1, 1, 1);
    #1 check("ldr_d_match", m12, 1);
    check("ldr_memtoreg_e", m2r_e, 1);
    tick();
    check("bubble_memtoreg", m2r_e, 0);
    check("bubble_e_matches", {m1em, m1ew, m2em, m2ew, m12}, 0);
    drive(4, 0, 7, 1, 0, 0, 1, 0, 0);
    tick();
    check("reissue_e_w", m1ew, 1);
    check("reissue_e_m_bub", m1em, 0);

    // Branch flag walks E -> M -> W for one cycle each
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("pcs_seq_e", {pcs_e, pcs_m, pcs_w}, 3'b100);
    tick();
    check("pcs_seq_m", {pcs_e, pcs_m, pcs_w}, 3'b010);
    tick();
    check("pcs_seq_w", {pcs_e, pcs_m, pcs_w}, 3'b001);
    tick();
    check("pcs_seq_done", {pcs_e, pcs_m, pcs_w}, 3'b000);

    // Same with the condition failing
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    check("pcs_nc_e", pcs_e, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("pcs_nc_m", pcs_m, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("pcs_nc_w", pcs_w, 0);

    // R15 never matches
    drive(0, 0, 15, 1, 0, 0, 1, 0, 0);
    tick();
    drive(15, 0, 1, 0, 0, 0, 1, 0, 0);
    #1 check("r15_no_match", m12, 0);

    // Bubble with WA3=0 and a read of R0
    drive(0, 0, 0, 1, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 1, 0, 0);
    #1 check("bubble_r0", m12, 0);

    // Asynchronous reset in the middle of traffic
    drive(5, 5, 5, 1, 1, 1, 1, 0, 1);
    tick(); tick();
    check("pre_reset_busy", {m12, rw_m, m2r_e, pcs_e}, 4'b1111);
    rst_n = 1'b0;
    #1 check("mid_reset_outs", {5'd0, dut_out}, 16'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    check("cnt_after_reset", stall_cnt, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    repeat (70000) @(posedge clk);
    #1 check("stall_saturate", stall_cnt, 16'hFFFF);
    check("flush_idle", flush_cnt, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
